regfile_sb: RTL and testbench

Parametrised general-purpose register file for the femtoRV32 datapath. It has two combinational read ports, one write port and an optional write-to-read bypass. It adds a per-register pending scoreboard for the pipelined core and a sequential clear engine that zeroes the array one entry per cycle on request. It sits between decode (read/issue) and writeback (write).

---
 rtl/regfile_sb_if.sv | 32 +++
 rtl/regfile_sb.sv | 144 ++++++++++++++
 tb/tb_regfile_sb.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bundle of the femtoRV32 register file with pending scoreboard.
// The master drives reads, writes, issues and clear requests; the slave is the register file.
interface regfile_sb_if #(
    parameter int N      = 32,
    parameter int ADDR_W = 5
);
    logic              clr_req;
    logic              busy;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteReg;
    logic [N-1:0]      WriteData;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [N-1:0]      ReadData1;
    logic [N-1:0]      ReadData2;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic              pend1;
    logic              pend2;

    modport master (
        output clr_req, RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
               issue_valid, issue_rd,
        input  busy, ReadData1, ReadData2, pend1, pend2
    );

    modport slave (
        input  clr_req, RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
               issue_valid, issue_rd,
        output busy, ReadData1, ReadData2, pend1, pend2
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write port, optional write bypass,
// per-register pending scoreboard and a one-entry-per-cycle clear engine.
//
// state | meaning
// IDLE  | normal operation; reads, writes and issues are serviced
// CLEAR | sweeping clrIdx from 1 to DEPTH-1; writes/issues dropped, reads return 0
module regfile_sb #(
    parameter int N      = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input logic          clk,
    input logic          rst,
    regfile_sb_if.slave  bus
);
    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX  = '1;
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    state_t            stateNext;
    logic [ADDR_W-1:0] clrIdx;
    logic [ADDR_W-1:0] clrIdxNext;
    logic              busyInt;
    logic              clrStart;

    logic [N-1:0]      regs [DEPTH];
    logic [DEPTH-1:0]  pending;

    logic              wrEn;
    logic              issEn;
    logic              fwd1;
    logic              fwd2;
    logic [N-1:0]      rd1;
    logic [N-1:0]      rd2;
    logic              p1;
    logic              p2;

    assign wrEn  = bus.RegWrite && !busyInt && (bus.WriteReg != '0);
    assign issEn = bus.issue_valid && !busyInt && (bus.issue_rd != '0);
    assign fwd1  = wrEn && (BYPASS != 0) && (bus.WriteReg == bus.ReadReg1);
    assign fwd2  = wrEn && (BYPASS != 0) && (bus.WriteReg == bus.ReadReg2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            clrIdx <= '0;
        end else begin
            state  <= stateNext;
            clrIdx <= clrIdxNext;
        end
    end

    // The sweep stops at LAST_IDX instead of letting clrIdx wrap back to 0.
    always_comb begin
        stateNext  = state;
        clrIdxNext = clrIdx;
        busyInt    = 1'b0;
        clrStart   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.clr_req) begin
                    stateNext  = CLEAR;
                    clrIdxNext = FIRST_IDX;
                    clrStart   = 1'b1;
                end
            end
            CLEAR: begin
                busyInt = 1'b1;
                if (clrIdx == LAST_IDX) begin
                    stateNext = IDLE;
                end else begin
                    clrIdxNext = clrIdx + FIRST_IDX;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (busyInt) begin
            regs[clrIdx] <= '0;
        end else if (wrEn) begin
            regs[bus.WriteReg] <= bus.WriteData;
        end
    end

    // Issue is applied after writeback so a same-cycle new producer keeps the bit set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else if (clrStart) begin
            pending <= '0;
        end else begin
            if (wrEn) begin
                pending[bus.WriteReg] <= 1'b0;
            end
            if (issEn) begin
                pending[bus.issue_rd] <= 1'b1;
            end
        end
    end

    always_comb begin
        rd1 = '0;
        p1  = 1'b0;
        if (!busyInt && (bus.ReadReg1 != '0)) begin
            if (fwd1) begin
                rd1 = bus.WriteData;
            end else begin
                rd1 = regs[bus.ReadReg1];
                p1  = pending[bus.ReadReg1];
            end
        end
    end

    always_comb begin
        rd2 = '0;
        p2  = 1'b0;
        if (!busyInt && (bus.ReadReg2 != '0)) begin
            if (fwd2) begin
                rd2 = bus.WriteData;
            end else begin
                rd2 = regs[bus.ReadReg2];
                p2  = pending[bus.ReadReg2];
            end
        end
    end

    assign bus.ReadData1 = rd1;
    assign bus.ReadData2 = rd2;
    assign bus.pend1     = p1;
    assign bus.pend2     = p2;
    assign bus.busy      = busyInt;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a bypassing instance carries most vectors, a
// non-bypassing instance checks the one-cycle write-to-read path.
module tb_regfile_sb;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    regfile_sb_if #(.N(32), .ADDR_W(5)) b1 ();
    regfile_sb_if #(.N(32), .ADDR_W(5)) b0 ();

    regfile_sb #(.N(32), .ADDR_W(5), .BYPASS(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
    regfile_sb #(.N(32), .ADDR_W(5), .BYPASS(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));

    typedef struct {
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        iv;
        logic [4:0]  ird;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        ep1;
        logic        ep2;
    } vec_t;

    vec_t vecs [15];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle1();
        b1.clr_req = 1'b0; b1.RegWrite = 1'b0; b1.WriteReg = '0; b1.WriteData = '0;
        b1.ReadReg1 = '0; b1.ReadReg2 = '0; b1.issue_valid = 1'b0; b1.issue_rd = '0;
    endtask

    task automatic idle0();
        b0.clr_req = 1'b0; b0.RegWrite = 1'b0; b0.WriteReg = '0; b0.WriteData = '0;
        b0.ReadReg1 = '0; b0.ReadReg2 = '0; b0.issue_valid = 1'b0; b0.issue_rd = '0;
    endtask

    // Counts post-edge samples with busy high; a hung engine returns 100.
    task automatic waitIdle(output int cnt);
        cnt = 0;
        while (b1.busy === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
    endtask

    task automatic checkAllZero(input string tag);
        for (int i = 0; i < 32; i++) begin
            b1.ReadReg1 = 5'(i);
            b1.ReadReg2 = 5'(31 - i);
            #1;
            chk({tag, "_rd1"}, b1.ReadData1, 32'h0);
            chk({tag, "_rd2"}, b1.ReadData2, 32'h0);
            chk({tag, "_p1"}, {31'b0, b1.pend1}, 32'h0);
            chk({tag, "_p2"}, {31'b0, b1.pend2}, 32'h0);
        end
    endtask

    initial begin
        int cnt;

        //            we    wr     wd            r1     r2     iv    ird    e1            e2            ep1   ep2
        vecs[0]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0};
        vecs[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  1'b0, 5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  1'b0, 5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
        vecs[3]  = '{1'b1, 5'd0,  32'h00001234, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  1'b0, 5'd0,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd7,  1'b0, 5'd0,  32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd0,  1'b1, 5'd9,  32'h0,        32'h0,        1'b0, 1'b0};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd7,  1'b0, 5'd0,  32'h0,        32'hA5A5A5A5, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 5'd9,  32'h11111111, 5'd9,  5'd0,  1'b0, 5'd0,  32'h11111111, 32'h0,        1'b0, 1'b0};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd0,  1'b0, 5'd0,  32'h11111111, 32'h0,        1'b0, 1'b0};
        vecs[10] = '{1'b1, 5'd9,  32'h22222222, 5'd9,  5'd0,  1'b1, 5'd9,  32'h22222222, 32'h0,        1'b0, 1'b0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd0,  1'b0, 5'd0,  32'h22222222, 32'h0,        1'b1, 1'b0};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  1'b1, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0};
        vecs[13] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd9,  1'b0, 5'd0,  32'h0,        32'h22222222, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 5'd9,  32'h00000003, 5'd5,  5'd9,  1'b0, 5'd0,  32'hDEADBEEF, 32'h00000003, 1'b0, 1'b0};

        rst = 1'b1;
        idle1();
        idle0();
        #12;
        rst = 1'b0;
        #1;
        chk("reset_busy", {31'b0, b1.busy}, 32'h0);
        chk("reset_busy_nobyp", {31'b0, b0.busy}, 32'h0);
        checkAllZero("reset");

        for (int v = 0; v < 15; v++) begin
            b1.RegWrite    = vecs[v].we;
            b1.WriteReg    = vecs[v].wr;
            b1.WriteData   = vecs[v].wd;
            b1.ReadReg1    = vecs[v].r1;
            b1.ReadReg2    = vecs[v].r2;
            b1.issue_valid = vecs[v].iv;
            b1.issue_rd    = vecs[v].ird;
            #1;
            chk($sformatf("vec%0d_rd1", v), b1.ReadData1, vecs[v].e1);
            chk($sformatf("vec%0d_rd2", v), b1.ReadData2, vecs[v].e2);
            chk($sformatf("vec%0d_p1", v), {31'b0, b1.pend1}, {31'b0, vecs[v].ep1});
            chk($sformatf("vec%0d_p2", v), {31'b0, b1.pend2}, {31'b0, vecs[v].ep2});
            tick();
        end
        idle1();

        // Without bypass the old value is visible in the write cycle.
        b0.RegWrite = 1'b1; b0.WriteReg = 5'd7; b0.WriteData = 32'h1;
        tick();
        b0.WriteData = 32'hA5A5A5A5; b0.ReadReg1 = 5'd7;
        #1;
        chk("nobyp_same_cycle", b0.ReadData1, 32'h1);
        tick();
        b0.RegWrite = 1'b0;
        #1;
        chk("nobyp_next_cycle", b0.ReadData1, 32'hA5A5A5A5);
        b0.issue_valid = 1'b1; b0.issue_rd = 5'd9; b0.ReadReg1 = 5'd9;
        #1;
        chk("nobyp_issue_same", {31'b0, b0.pend1}, 32'h0);
        tick();
        b0.issue_valid = 1'b0;
        #1;
        chk("nobyp_issue_next", {31'b0, b0.pend1}, 32'h1);
        b0.RegWrite = 1'b1; b0.WriteReg = 5'd9; b0.WriteData = 32'h5;
        #1;
        chk("nobyp_wb_pend_same", {31'b0, b0.pend1}, 32'h1);
        chk("nobyp_wb_data_same", b0.ReadData1, 32'h0);
        tick();
        b0.RegWrite = 1'b0;
        #1;
        chk("nobyp_wb_pend_next", {31'b0, b0.pend1}, 32'h0);
        chk("nobyp_wb_data_next", b0.ReadData1, 32'h5);
        idle0();

        // Fill, then a single-cycle clear with dropped write/issue mid-sweep.
        for (int i = 1; i < 32; i++) begin
            b1.RegWrite = 1'b1; b1.WriteReg = 5'(i); b1.WriteData = 32'h10000000 | i;
            b1.issue_valid = (i == 31); b1.issue_rd = 5'd12;
            tick();
        end
        idle1();
        b1.ReadReg1 = 5'd31; b1.ReadReg2 = 5'd12;
        #1;
        chk("fill_x31", b1.ReadData1, 32'h1000001F);
        chk("fill_x12", b1.ReadData2, 32'h1000000C);
        chk("fill_pend12", {31'b0, b1.pend2}, 32'h1);
        b1.clr_req = 1'b1;
        tick();
        b1.clr_req = 1'b0;
        chk("clr_busy_rise", {31'b0, b1.busy}, 32'h1);
        cnt = 0;
        while (b1.busy === 1'b1 && cnt < 100) begin
            if (cnt == 10) begin
                b1.RegWrite = 1'b1; b1.WriteReg = 5'd3; b1.WriteData = 32'hFFFF;
                b1.issue_valid = 1'b1; b1.issue_rd = 5'd4;
                b1.ReadReg1 = 5'd25; b1.ReadReg2 = 5'd3;
                #1;
                chk("busy_rd1_masked", b1.ReadData1, 32'h0);
                chk("busy_rd2_nobypass", b1.ReadData2, 32'h0);
                chk("busy_p2_masked", {31'b0, b1.pend2}, 32'h0);
            end else if (cnt == 11) begin
                idle1();
            end
            cnt++;
            tick();
        end
        chk("clr_busy_cycles", cnt, 31);
        checkAllZero("after_clr");

        // clr_req held: re-accepted at the first edge with busy low.
        b1.clr_req = 1'b1;
        tick();
        chk("held_busy_rise", {31'b0, b1.busy}, 32'h1);
        waitIdle(cnt);
        chk("held_first_cycles", cnt, 31);
        chk("held_busy_low", {31'b0, b1.busy}, 32'h0);
        tick();
        chk("held_rearm", {31'b0, b1.busy}, 32'h1);
        b1.clr_req = 1'b0;
        waitIdle(cnt);
        chk("held_second_cycles", cnt, 31);

        // clr_req pulsed mid-sweep is not queued.
        b1.clr_req = 1'b1;
        tick();
        b1.clr_req = 1'b0;
        cnt = 0;
        while (b1.busy === 1'b1 && cnt < 100) begin
            b1.clr_req = (cnt == 5);
            cnt++;
            tick();
        end
        b1.clr_req = 1'b0;
        chk("pulse_cycles", cnt, 31);
        tick();
        chk("pulse_ignored", {31'b0, b1.busy}, 32'h0);

        // Reset during the sweep aborts it and zeroes everything.
        b1.RegWrite = 1'b1; b1.WriteReg = 5'd20; b1.WriteData = 32'h55;
        b1.issue_valid = 1'b1; b1.issue_rd = 5'd20;
        tick();
        idle1();
        b1.ReadReg1 = 5'd20;
        #1;
        chk("pre_rst_x20", b1.ReadData1, 32'h55);
        chk("pre_rst_pend20", {31'b0, b1.pend1}, 32'h1);
        b1.clr_req = 1'b1;
        tick();
        b1.clr_req = 1'b0;
        repeat (9) tick();
        chk("rst_mid_busy_before", {31'b0, b1.busy}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", {31'b0, b1.busy}, 32'h0);
        chk("rst_mid_x20", b1.ReadData1, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_x20", b1.ReadData1, 32'h0);
        chk("post_rst_pend20", {31'b0, b1.pend1}, 32'h0);
        tick();
        chk("post_rst_busy", {31'b0, b1.busy}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
